dcache_controller: RTL and testbench
====================================

# dcache_controller

Sequencing controller for the CPU's direct-mapped data cache: 8 lines, one 32-bit word per line, 27-bit tag, 3-bit set, 2-bit byte offset. It sits between the load/store stage and data memory. It performs the lookup, refills the line on a read miss, and writes through to memory on every store. It stalls the CPU through a request/ready handshake and keeps hit/miss counters for performance measurement.

## Interface
Parameters:
- DATA_WIDTH, 32, word and address width
- TAG_WIDTH, 27, tag bits (address[31:5])
- SET_WIDTH, 3, set index bits (address[4:2])
- OFFSET_WIDTH, 2, byte offset bits (address[1:0]), ignored
- CACHE_WIDTH, 8, number of lines (2**SET_WIDTH)
- CNT_WIDTH, 16, hit/miss counter width

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; held with address/data stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  DATA_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data, valid only while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  DATA_WIDTH  word-aligned memory address (low 2 bits zero)
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- hit_count  out  CNT_WIDTH  completed read hits, wraps
- miss_count  out  CNT_WIDTH  read misses, wraps

## Operation
- Address split: tag = addr[31:5], set = addr[4:2]. Offset is ignored, so every access is a full word.
- Hit = V[set] && tag[set] == addr tag, evaluated combinationally in IDLE.
- FSM states: IDLE, REFILL, WRITE, RESPOND.
- IDLE with flush=1: all V cleared at the edge; cpu_req is not serviced that cycle, regardless of request.
- IDLE, read hit: cpu_ready=1 and cpu_rdata = data[set] in the same cycle; hit_count+1; stay in IDLE.
- IDLE, read miss: miss_count+1 and go to REFILL.
- IDLE, store: go to WRITE, whether hit or miss.
- REFILL: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. On mem_ready, write V=1, the tag and mem_rdata into the set, latch mem_rdata, and go to RESPOND.
- RESPOND: cpu_ready=1 with the latched data, then go to IDLE.
- WRITE: mem_req=1, mem_we=1, mem_wdata=cpu_wdata. On mem_ready, pulse cpu_ready that cycle and go to IDLE. If the line hit at IDLE, update its data at the same edge.
- Store miss: no allocate; cache unchanged.
- flush outside IDLE is ignored; the requester holds it.
- Counters: no increment for stores or flushes; wrap modulo 2**CNT_WIDTH.

## Timing
- Reset values: state=IDLE, all V=0, cpu_ready=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, hit_count=0, miss_count=0.
- Read hit latency: 0 cycles, with cpu_ready in the request cycle.
- Read miss latency: N+2 cycles, where N is the number of cycles mem_req is held before mem_ready.
- Store latency: N+1 cycles, with cpu_ready in the mem_ready cycle.
- mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the mem_ready cycle inclusive. mem_req drops the cycle after.
- mem_ready arriving while mem_req=0 is ignored.
- cpu_req dropping before cpu_ready is a protocol violation and undefined.
- Reset during REFILL or WRITE: the FSM returns to IDLE and mem_req=0 on the next cycle; the memory transaction is abandoned and no line is written.
- Back-to-back: a new cpu_req may be serviced in the cycle after cpu_ready.

## Structure
- Package cache_pkg holds the width parameters as localparams, the state enum, and a packed address struct {tag, set, offset}.
- Sub-module dcache_array holds the storage:
  - V/tag/data arrays
  - combinational read by set with hit output
  - synchronous single-port write
  - single-cycle flush of V
  - reset clear of V
- dcache_controller holds the FSM, the response latch and the counters.

## Test plan
- Reset, then read 0x0000_0010; memory returns 0xDEADBEEF 2 cycles after mem_req. Required: mem_addr=0x10; cpu_ready 4 cycles after the request with 0xDEADBEEF; miss_count=1.
- Repeat the read of 0x10. Required: cpu_ready in the same cycle with 0xDEADBEEF, no mem_req, hit_count=1.
- Read 0x30, which maps to the same set (4), returning 0x12345678, then read 0x10 again. Required: two misses, miss_count=3, and a refill for 0x10.
- Store 0xCAFEF00D to 0x10 (a hit), then read 0x10. Required: mem_we=1, mem_wdata=0xCAFEF00D, and the read hits with 0xCAFEF00D. Then store to 0x50 (a miss) and read 0x50. Required: the read misses, showing no allocate.
- Assert flush in IDLE together with cpu_req read 0x10. Required: no cpu_ready that cycle; the next cycle is a miss.
- Assert rst mid-REFILL. Required: mem_req=0 the next cycle, counters=0, and the next read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state encoding and address layout for the data cache.
package cache_pkg;
    localparam int DATA_WIDTH   = 32;
    localparam int TAG_WIDTH    = 27;
    localparam int SET_WIDTH    = 3;
    localparam int OFFSET_WIDTH = 2;
    localparam int CACHE_WIDTH  = 8;
    localparam int CNT_WIDTH    = 16;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]    tag;
        logic [SET_WIDTH-1:0]    set;
        logic [OFFSET_WIDTH-1:0] offset;
    } addr_t;

    function automatic logic [DATA_WIDTH-1:0] word_addr(addr_t a);
        return {a.tag, a.set, {OFFSET_WIDTH{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// dcache_if: CPU-side and memory-side buses of the data cache controller.
interface dcache_if;
    import cache_pkg::*;
    logic                  cpu_req, cpu_we, cpu_ready, flush;
    logic [DATA_WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic                  mem_req, mem_we, mem_ready;
    logic [DATA_WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [CNT_WIDTH-1:0]  hit_count, miss_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage with combinational lookup.
module dcache_array
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  we,
    input  logic [SET_WIDTH-1:0]  set,
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [CACHE_WIDTH-1:0] valid_q, valid_d;
    logic [TAG_WIDTH-1:0]   tag_q  [CACHE_WIDTH];
    logic [TAG_WIDTH-1:0]   tag_d  [CACHE_WIDTH];
    logic [DATA_WIDTH-1:0]  data_q [CACHE_WIDTH];
    logic [DATA_WIDTH-1:0]  data_d [CACHE_WIDTH];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (flush) valid_d = '0;
        else if (we) begin
            valid_d[set] = 1'b1;
            tag_d[set]   = tag;
            data_d[set]  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // Tag and data need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit     = valid_q[set] && (tag_q[set] == tag);
    assign rd_data = data_q[set];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: lookup/refill/write-through sequencer for a direct-mapped data cache.
module dcache_controller
    import cache_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    dcache_if.slave  bus
);
    addr_t                 a;
    state_t                state_q, state_d;
    logic                  hit, rd_hit, done, arr_we, flush_en;
    logic                  store_hit_q, store_hit_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] rd_data, arr_wdata;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, resp_q, resp_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    assign a        = addr_t'(bus.cpu_addr);
    assign done     = mem_req_q && bus.mem_ready;
    assign flush_en = (state_q == IDLE) && bus.flush;
    assign rd_hit   = (state_q == IDLE) && !bus.flush && bus.cpu_req && !bus.cpu_we && hit;

    dcache_array u_array (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_en),
        .we      (arr_we),
        .set     (a.set),
        .tag     (a.tag),
        .wr_data (arr_wdata),
        .hit     (hit),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        store_hit_d = store_hit_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        resp_d      = resp_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        arr_we      = 1'b0;
        arr_wdata   = bus.mem_rdata;
        case (state_q)
            IDLE: if (!bus.flush && bus.cpu_req) begin
                if (bus.cpu_we) begin
                    state_d     = WRITE;
                    store_hit_d = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr(a);
                    mem_wdata_d = bus.cpu_wdata;
                end else if (hit) hit_cnt_d = hit_cnt_q + 1'b1;
                else begin
                    state_d    = REFILL;
                    miss_cnt_d = miss_cnt_q + 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = word_addr(a);
                end
            end
            REFILL: if (done) begin
                arr_we    = 1'b1;
                resp_d    = bus.mem_rdata;
                mem_req_d = 1'b0;
                state_d   = RESPOND;
            end
            RESPOND: state_d = IDLE;
            WRITE: if (done) begin
                // Write-through without allocate: only a line that hit is refreshed.
                arr_we    = store_hit_q;
                arr_wdata = bus.cpu_wdata;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            store_hit_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            store_hit_q <= store_hit_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            resp_q      <= resp_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.cpu_ready  = rd_hit || (state_q == RESPOND) || ((state_q == WRITE) && done);
    assign bus.cpu_rdata  = rd_hit ? rd_data : resp_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed stimulus with queued expectations checked by CPU and memory monitors.
module tb_dcache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    dcache_if bus();

    dcache_controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {logic ld; logic [31:0] data; int lat;} cpu_exp_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} mem_exp_t;

    cpu_exp_t cq[$];
    mem_exp_t mq[$];
    int checks = 0, errors = 0, mdly = 2, lat = 0, mcnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // CPU monitor: latency counted in request cycles before cpu_ready.
    always @(negedge clk) begin : cpu_mon
        cpu_exp_t e;
        if (rst) lat = 0;
        else if (bus.cpu_req) begin
            if (bus.cpu_ready) begin
                if (cq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected cpu_ready addr %h", bus.cpu_addr);
                end else begin
                    e = cq.pop_front();
                    chk("latency", lat, e.lat);
                    if (e.ld) chk("cpu_rdata", bus.cpu_rdata, e.data);
                end
                lat = 0;
            end else lat++;
        end else if (bus.cpu_ready) begin
            checks++; errors++;
            $display("FAIL cpu_ready without request");
        end
    end

    // Memory model: answers mdly cycles after mem_req first appears.
    always @(posedge clk) begin : mem_mon
        mem_exp_t e;
        #1;
        if (!bus.mem_req) begin
            mcnt = 0;
            bus.mem_ready = 1'b0;
        end else begin
            if (mcnt == 0) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected mem_req addr %h", bus.mem_addr);
                end
            end
            mcnt++;
            if (mcnt == mdly + 1 && mq.size() != 0) begin
                e = mq.pop_front();
                chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                chk("mem_addr", bus.mem_addr, e.addr);
                if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
                bus.mem_rdata = e.rdata;
                bus.mem_ready = 1'b1;
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic fl);
        bit ok = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.flush = fl;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) ok = 1;
            else begin
                @(posedge clk); #1;
                bus.flush = 1'b0;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL timeout waiting cpu_ready addr %h", addr);
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input int l, input logic miss);
        if (miss) mq.push_back('{1'b0, addr & 32'hFFFF_FFFC, 32'h0, exp});
        cq.push_back('{1'b1, exp, l});
        access(1'b0, addr, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int l);
        mq.push_back('{1'b1, addr & 32'hFFFF_FFFC, data, 32'h0});
        cq.push_back('{1'b0, 32'h0, l});
        access(1'b1, addr, data, 1'b0);
    endtask

    task automatic counters(input string tag, input int h, input int m);
        chk({tag, " hit_count"}, {16'b0, bus.hit_count}, h);
        chk({tag, " miss_count"}, {16'b0, bus.miss_count}, m);
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.flush = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        repeat (2) @(posedge clk); #1;
        chk("reset cpu_ready", {31'b0, bus.cpu_ready}, 0);
        chk("reset cpu_rdata", bus.cpu_rdata, 0);
        chk("reset mem_req", {31'b0, bus.mem_req}, 0);
        chk("reset mem_we", {31'b0, bus.mem_we}, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset mem_wdata", bus.mem_wdata, 0);
        counters("reset", 0, 0);
        rst = 1'b0;

        rd(32'h10, 32'hDEADBEEF, 4, 1);
        counters("first miss", 0, 1);
        rd(32'h10, 32'hDEADBEEF, 0, 0);
        counters("first hit", 1, 1);
        rd(32'h30, 32'h12345678, 4, 1);
        rd(32'h13, 32'hDEADBEEF, 4, 1);
        counters("conflict", 1, 3);

        wr(32'h10, 32'hCAFEF00D, 3);
        rd(32'h10, 32'hCAFEF00D, 0, 0);
        counters("store hit", 2, 3);
        wr(32'h50, 32'h11112222, 3);
        rd(32'h50, 32'hA5A5A5A5, 4, 1);
        counters("store miss", 2, 4);

        mdly = 0;
        wr(32'h14, 32'h5555AAAA, 1);
        rd(32'h24, 32'h0BADF00D, 2, 1);
        mdly = 2;
        counters("zero wait", 2, 5);

        mq.push_back('{1'b0, 32'h50, 32'h0, 32'hA5A5A5A5});
        cq.push_back('{1'b1, 32'hA5A5A5A5, 5});
        access(1'b0, 32'h50, 32'h0, 1'b1);
        rd(32'h24, 32'h0BADF00D, 4, 1);
        rd(32'h24, 32'h0BADF00D, 0, 0);
        counters("flush", 3, 7);

        mq.push_back('{1'b0, 32'h64, 32'h0, 32'h0});
        mdly = 20;
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h64; bus.cpu_req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("refill mem_req", {31'b0, bus.mem_req}, 1);
        @(posedge clk); #1;
        rst = 1'b1; bus.cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort mem_req", {31'b0, bus.mem_req}, 0);
        counters("abort", 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        mdly = 2;
        rd(32'h64, 32'h77778888, 4, 1);
        counters("after abort", 0, 1);

        chk("cpu queue drained", cq.size(), 0);
        chk("mem queue drained", mq.size(), 0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
